cdma_axi_arbiter: RTL and testbench

- Shares one downstream AXI4 master port, feeding the CDMA address window, between two upstream AXI4 requesters: port 0 is the CDMA engine and port 1 is the debug/loader master.
- Write and read paths are arbitrated independently, each with round-robin priority.
- At most one write burst and one read burst are in flight downstream at any time, so responses are routed by ownership rather than by ID.

---
 rtl/cdma_arb_pkg.sv | 7 +
 rtl/rr_arb2.sv | 31 +++
 rtl/cdma_axi_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_cdma_axi_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdma_arb_pkg.sv
// cdma_arb_pkg: shared FSM state encodings and owner constants for the CDMA AXI arbiter
package cdma_arb_pkg;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin arbiter
//   aclk/aresetn : clock, asynchronous active-low reset
//   req[1:0]     : requests (already masked by the caller when not arbitrating)
//   advance      : grant accepted; pointer flips to favour the other port
//   grant[1:0]   : one-hot grant, held stable while the granted request stays up
module rr_arb2 (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic       ptr, held;
  logic [1:0] held_g, raw_g;
  // once a grant is shown without being taken it is frozen, so a late
  // request from the other port cannot steal a pending AXI valid
  always_comb begin
    raw_g = (&req) ? (ptr ? 2'b10 : 2'b01) : req;
    grant = held ? (held_g & req) : raw_g;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      ptr    <= 1'b0;
      held   <= 1'b0;
      held_g <= 2'b00;
    end else begin
      if (advance) ptr <= grant[0];
      held   <= (|grant) && !advance;
      held_g <= grant;
    end
endmodule

// File: rtl/cdma_axi_arbiter.sv
// cdma_axi_arbiter: shares one AXI4 master between the CDMA engine (s0) and the debug/loader (s1)
//   aclk/aresetn : clock, asynchronous active-low reset
//   s0_axi_*     : AXI4 slave port, requester 0 (CDMA engine)
//   s1_axi_*     : AXI4 slave port, requester 1 (debug/loader)
//   m_axi_*      : shared AXI4 master port
//   wr_owner/wr_busy, rd_owner/rd_busy : current burst ownership
//   CDMA_ADDR_REMAP_EN : when defined, forces address MSB high (CDMA high window)
module cdma_axi_arbiter
  import cdma_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     s0_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic [7:0]              s0_axi_awlen,
  input  logic [2:0]              s0_axi_awsize,
  input  logic [1:0]              s0_axi_awburst,
  input  logic                    s0_axi_awlock,
  input  logic [3:0]              s0_axi_awcache,
  input  logic [2:0]              s0_axi_awprot,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wlast,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [ID_WIDTH-1:0]     s0_axi_bid,
  output logic [1:0]              s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ID_WIDTH-1:0]     s0_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic [7:0]              s0_axi_arlen,
  input  logic [2:0]              s0_axi_arsize,
  input  logic [1:0]              s0_axi_arburst,
  input  logic                    s0_axi_arlock,
  input  logic [3:0]              s0_axi_arcache,
  input  logic [2:0]              s0_axi_arprot,
  input  logic [3:0]              s0_axi_arqos,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [ID_WIDTH-1:0]     s0_axi_rid,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [1:0]              s0_axi_rresp,
  output logic                    s0_axi_rlast,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  input  logic [ID_WIDTH-1:0]     s1_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic [7:0]              s1_axi_awlen,
  input  logic [2:0]              s1_axi_awsize,
  input  logic [1:0]              s1_axi_awburst,
  input  logic                    s1_axi_awlock,
  input  logic [3:0]              s1_axi_awcache,
  input  logic [2:0]              s1_axi_awprot,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wlast,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [ID_WIDTH-1:0]     s1_axi_bid,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ID_WIDTH-1:0]     s1_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic [7:0]              s1_axi_arlen,
  input  logic [2:0]              s1_axi_arsize,
  input  logic [1:0]              s1_axi_arburst,
  input  logic                    s1_axi_arlock,
  input  logic [3:0]              s1_axi_arcache,
  input  logic [2:0]              s1_axi_arprot,
  input  logic [3:0]              s1_axi_arqos,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [ID_WIDTH-1:0]     s1_axi_rid,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rlast,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    wr_owner,
  output logic                    wr_busy,
  output logic                    rd_owner,
  output logic                    rd_busy
);
  wr_state_t             w_state, w_next;
  rd_state_t             r_state, r_next;
  logic                  w_own, r_own, aw_sel, ar_sel;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, w_act, b_act, r_act;
  logic [1:0]            aw_req, aw_g, ar_req, ar_g;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  // requests are masked by reset so every valid/ready output drops asynchronously
  assign aw_req = {s1_axi_awvalid, s0_axi_awvalid} & {2{aresetn && w_state == W_IDLE}};
  assign ar_req = {s1_axi_arvalid, s0_axi_arvalid} & {2{aresetn && r_state == R_IDLE}};
  rr_arb2 u_aw_arb (.aclk(aclk), .aresetn(aresetn), .req(aw_req), .advance(aw_hs), .grant(aw_g));
  rr_arb2 u_ar_arb (.aclk(aclk), .aresetn(aresetn), .req(ar_req), .advance(ar_hs), .grant(ar_g));
  assign aw_sel = aw_g[1];
  assign ar_sel = ar_g[1];
  assign w_act  = w_state == W_DATA;
  assign b_act  = w_state == W_RESP;
  assign r_act  = r_state == R_DATA;
  assign m_axi_awvalid  = |aw_g;
  assign s0_axi_awready = aw_g[0] & m_axi_awready;
  assign s1_axi_awready = aw_g[1] & m_axi_awready;
  assign aw_hs          = m_axi_awvalid & m_axi_awready;
  assign m_axi_awid     = aw_sel ? s1_axi_awid    : s0_axi_awid;
  assign aw_addr        = aw_sel ? s1_axi_awaddr  : s0_axi_awaddr;
  assign m_axi_awlen    = aw_sel ? s1_axi_awlen   : s0_axi_awlen;
  assign m_axi_awsize   = aw_sel ? s1_axi_awsize  : s0_axi_awsize;
  assign m_axi_awburst  = aw_sel ? s1_axi_awburst : s0_axi_awburst;
  assign m_axi_awlock   = aw_sel ? s1_axi_awlock  : s0_axi_awlock;
  assign m_axi_awcache  = aw_sel ? s1_axi_awcache : s0_axi_awcache;
  assign m_axi_awprot   = aw_sel ? s1_axi_awprot  : s0_axi_awprot;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_wvalid   = w_act & (w_own ? s1_axi_wvalid : s0_axi_wvalid);
  assign s0_axi_wready  = w_act & ~w_own & m_axi_wready;
  assign s1_axi_wready  = w_act & w_own & m_axi_wready;
  assign m_axi_wdata    = w_own ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb    = w_own ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast    = w_own ? s1_axi_wlast : s0_axi_wlast;
  assign w_hs           = m_axi_wvalid & m_axi_wready;
  assign s0_axi_bvalid  = b_act & ~w_own & m_axi_bvalid;
  assign s1_axi_bvalid  = b_act & w_own & m_axi_bvalid;
  assign m_axi_bready   = b_act & (w_own ? s1_axi_bready : s0_axi_bready);
  assign s0_axi_bid     = m_axi_bid;
  assign s1_axi_bid     = m_axi_bid;
  assign s0_axi_bresp   = m_axi_bresp;
  assign s1_axi_bresp   = m_axi_bresp;
  assign b_hs           = m_axi_bvalid & m_axi_bready;
  assign m_axi_arvalid  = |ar_g;
  assign s0_axi_arready = ar_g[0] & m_axi_arready;
  assign s1_axi_arready = ar_g[1] & m_axi_arready;
  assign ar_hs          = m_axi_arvalid & m_axi_arready;
  assign m_axi_arid     = ar_sel ? s1_axi_arid    : s0_axi_arid;
  assign ar_addr        = ar_sel ? s1_axi_araddr  : s0_axi_araddr;
  assign m_axi_arlen    = ar_sel ? s1_axi_arlen   : s0_axi_arlen;
  assign m_axi_arsize   = ar_sel ? s1_axi_arsize  : s0_axi_arsize;
  assign m_axi_arburst  = ar_sel ? s1_axi_arburst : s0_axi_arburst;
  assign m_axi_arlock   = ar_sel ? s1_axi_arlock  : s0_axi_arlock;
  assign m_axi_arcache  = ar_sel ? s1_axi_arcache : s0_axi_arcache;
  assign m_axi_arprot   = ar_sel ? s1_axi_arprot  : s0_axi_arprot;
  assign m_axi_arqos    = ar_sel ? s1_axi_arqos   : s0_axi_arqos;
  assign s0_axi_rvalid  = r_act & ~r_own & m_axi_rvalid;
  assign s1_axi_rvalid  = r_act & r_own & m_axi_rvalid;
  assign m_axi_rready   = r_act & (r_own ? s1_axi_rready : s0_axi_rready);
  assign s0_axi_rid     = m_axi_rid;
  assign s1_axi_rid     = m_axi_rid;
  assign s0_axi_rdata   = m_axi_rdata;
  assign s1_axi_rdata   = m_axi_rdata;
  assign s0_axi_rresp   = m_axi_rresp;
  assign s1_axi_rresp   = m_axi_rresp;
  assign s0_axi_rlast   = m_axi_rlast;
  assign s1_axi_rlast   = m_axi_rlast;
  assign r_hs           = m_axi_rvalid & m_axi_rready;
`ifdef CDMA_ADDR_REMAP_EN
  assign m_axi_awaddr = {1'b1, aw_addr[ADDR_WIDTH-2:0]};
  assign m_axi_araddr = {1'b1, ar_addr[ADDR_WIDTH-2:0]};
`else
  assign m_axi_awaddr = aw_addr;
  assign m_axi_araddr = ar_addr;
`endif
  assign wr_owner = w_own;
  assign rd_owner = r_own;
  assign wr_busy  = w_state != W_IDLE;
  assign rd_busy  = r_state != R_IDLE;
  always_comb begin
    w_next = (w_state == W_IDLE && aw_hs) ? W_DATA :
             (w_act && w_hs && m_axi_wlast) ? W_RESP :
             (b_act && b_hs) ? W_IDLE : w_state;
    r_next = (r_state == R_IDLE && ar_hs) ? R_DATA :
             (r_act && r_hs && m_axi_rlast) ? R_IDLE : r_state;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_own   <= PORT0;
      r_own   <= PORT0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (aw_hs) w_own <= aw_sel ? PORT1 : PORT0;
      if (ar_hs) r_own <= ar_sel ? PORT1 : PORT0;
    end
endmodule

// File: tb/tb_cdma_axi_arbiter.sv
// tb_cdma_axi_arbiter: directed self-checking bench for cdma_axi_arbiter
module tb_cdma_axi_arbiter;
  logic aclk = 1'b0, aresetn = 1'b0;
  always #5 aclk = ~aclk;
  int errors = 0, checks = 0;

  logic [3:0]  s0_axi_awid, s1_axi_awid, s0_axi_arid, s1_axi_arid;
  logic [31:0] s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
  logic [7:0]  s0_axi_awlen, s1_axi_awlen, s0_axi_arlen, s1_axi_arlen;
  logic [2:0]  s0_axi_awsize, s1_axi_awsize, s0_axi_arsize, s1_axi_arsize;
  logic [1:0]  s0_axi_awburst, s1_axi_awburst, s0_axi_arburst, s1_axi_arburst;
  logic        s0_axi_awlock, s1_axi_awlock, s0_axi_arlock, s1_axi_arlock;
  logic [3:0]  s0_axi_awcache, s1_axi_awcache, s0_axi_arcache, s1_axi_arcache;
  logic [2:0]  s0_axi_awprot, s1_axi_awprot, s0_axi_arprot, s1_axi_arprot;
  logic [3:0]  s0_axi_arqos, s1_axi_arqos;
  logic        s0_axi_awvalid, s1_axi_awvalid, s0_axi_awready, s1_axi_awready;
  logic [63:0] s0_axi_wdata, s1_axi_wdata;
  logic [7:0]  s0_axi_wstrb, s1_axi_wstrb;
  logic        s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid, s0_axi_wready, s1_axi_wready;
  logic [3:0]  s0_axi_bid, s1_axi_bid;
  logic [1:0]  s0_axi_bresp, s1_axi_bresp;
  logic        s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
  logic        s0_axi_arvalid, s1_axi_arvalid, s0_axi_arready, s1_axi_arready;
  logic [3:0]  s0_axi_rid, s1_axi_rid;
  logic [63:0] s0_axi_rdata, s1_axi_rdata;
  logic [1:0]  s0_axi_rresp, s1_axi_rresp;
  logic        s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid, s0_axi_rready, s1_axi_rready;
  logic [3:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [31:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
  logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [63:0] m_axi_wdata, m_axi_rdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        wr_owner, wr_busy, rd_owner, rd_busy;

  cdma_axi_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axi_awid(s0_axi_awid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awlen(s0_axi_awlen),
    .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst), .s0_axi_awlock(s0_axi_awlock),
    .s0_axi_awcache(s0_axi_awcache), .s0_axi_awprot(s0_axi_awprot), .s0_axi_awvalid(s0_axi_awvalid),
    .s0_axi_awready(s0_axi_awready), .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb),
    .s0_axi_wlast(s0_axi_wlast), .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready), .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr),
    .s0_axi_arlen(s0_axi_arlen), .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst),
    .s0_axi_arlock(s0_axi_arlock), .s0_axi_arcache(s0_axi_arcache), .s0_axi_arprot(s0_axi_arprot),
    .s0_axi_arqos(s0_axi_arqos), .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_awid(s1_axi_awid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awlen(s1_axi_awlen),
    .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst), .s1_axi_awlock(s1_axi_awlock),
    .s1_axi_awcache(s1_axi_awcache), .s1_axi_awprot(s1_axi_awprot), .s1_axi_awvalid(s1_axi_awvalid),
    .s1_axi_awready(s1_axi_awready), .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb),
    .s1_axi_wlast(s1_axi_wlast), .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready), .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr),
    .s1_axi_arlen(s1_axi_arlen), .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst),
    .s1_axi_arlock(s1_axi_arlock), .s1_axi_arcache(s1_axi_arcache), .s1_axi_arprot(s1_axi_arprot),
    .s1_axi_arqos(s1_axi_arqos), .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .wr_owner(wr_owner), .wr_busy(wr_busy), .rd_owner(rd_owner), .rd_busy(rd_busy)
  );

  typedef struct packed {
    logic        p;
    logic        rd;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] exp_addr;
  } vec_t;

  function automatic logic [31:0] remap(input logic [31:0] a);
`ifdef CDMA_ADDR_REMAP_EN
    return a | 32'h8000_0000;
`else
    return a;
`endif
  endfunction

  function automatic logic [63:0] pat(input logic p, input logic [3:0] id, input int b);
    return {24'hC0DE00, 3'd0, p, id, 32'(b)};
  endfunction

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  task automatic aw_drive(input logic p, input logic v, input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
    if (p) begin s1_axi_awvalid = v; s1_axi_awid = id; s1_axi_awaddr = a; s1_axi_awlen = len; end
    else begin s0_axi_awvalid = v; s0_axi_awid = id; s0_axi_awaddr = a; s0_axi_awlen = len; end
  endtask

  task automatic ar_drive(input logic p, input logic v, input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
    if (p) begin s1_axi_arvalid = v; s1_axi_arid = id; s1_axi_araddr = a; s1_axi_arlen = len; end
    else begin s0_axi_arvalid = v; s0_axi_arid = id; s0_axi_araddr = a; s0_axi_arlen = len; end
  endtask

  task automatic w_drive(input logic p, input logic v, input logic [63:0] d, input logic last);
    if (p) begin s1_axi_wvalid = v; s1_axi_wdata = d; s1_axi_wlast = last; end
    else begin s0_axi_wvalid = v; s0_axi_wdata = d; s0_axi_wlast = last; end
  endtask

  task automatic do_write(input logic p, input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [31:0] ea);
    @(negedge aclk);
    aw_drive(p, 1'b1, id, a, len);
    m_axi_awready = 1'b1;
    #1;
    chk("aw_valid", m_axi_awvalid, 1);
    chk("aw_id", m_axi_awid, id);
    chk("aw_addr", m_axi_awaddr, ea);
    chk("aw_len", m_axi_awlen, len);
    chk("aw_burst", m_axi_awburst, p ? 2'd2 : 2'd1);
    chk("aw_qos", m_axi_awqos, 0);
    chk("aw_ready_own", p ? s1_axi_awready : s0_axi_awready, 1);
    chk("aw_ready_other", p ? s0_axi_awready : s1_axi_awready, 0);
    chk("wr_busy_pre", wr_busy, 0);
    @(posedge aclk);
    #1;
    aw_drive(p, 1'b0, id, a, len);
    m_axi_awready = 1'b0;
    chk("wr_busy_on", wr_busy, 1);
    chk("wr_owner", wr_owner, p);
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge aclk);
      w_drive(p, 1'b1, pat(p, id, b), b == int'(len));
      m_axi_wready = 1'b1;
      #1;
      chk("w_valid", m_axi_wvalid, 1);
      chk("w_data", m_axi_wdata, pat(p, id, b));
      chk("w_last", m_axi_wlast, b == int'(len));
      chk("w_ready_own", p ? s1_axi_wready : s0_axi_wready, 1);
      chk("w_ready_other", p ? s0_axi_wready : s1_axi_wready, 0);
      @(posedge aclk);
      #1;
      w_drive(p, 1'b0, 64'd0, 1'b0);
      m_axi_wready = 1'b0;
    end
    @(negedge aclk);
    m_axi_bvalid = 1'b1;
    m_axi_bid = id;
    m_axi_bresp = 2'd0;
    if (p) s1_axi_bready = 1'b1; else s0_axi_bready = 1'b1;
    #1;
    chk("b_valid_own", p ? s1_axi_bvalid : s0_axi_bvalid, 1);
    chk("b_valid_other", p ? s0_axi_bvalid : s1_axi_bvalid, 0);
    chk("b_id", p ? s1_axi_bid : s0_axi_bid, id);
    chk("b_ready", m_axi_bready, 1);
    chk("wr_busy_b", wr_busy, 1);
    @(posedge aclk);
    #1;
    m_axi_bvalid = 1'b0;
    s0_axi_bready = 1'b0;
    s1_axi_bready = 1'b0;
    chk("wr_busy_off", wr_busy, 0);
  endtask

  task automatic do_read(input logic p, input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [31:0] ea);
    @(negedge aclk);
    ar_drive(p, 1'b1, id, a, len);
    m_axi_arready = 1'b1;
    #1;
    chk("ar_valid", m_axi_arvalid, 1);
    chk("ar_id", m_axi_arid, id);
    chk("ar_addr", m_axi_araddr, ea);
    chk("ar_len", m_axi_arlen, len);
    chk("ar_qos", m_axi_arqos, p ? 4'h9 : 4'h3);
    chk("ar_ready_own", p ? s1_axi_arready : s0_axi_arready, 1);
    chk("ar_ready_other", p ? s0_axi_arready : s1_axi_arready, 0);
    chk("rd_busy_pre", rd_busy, 0);
    @(posedge aclk);
    #1;
    ar_drive(p, 1'b0, id, a, len);
    m_axi_arready = 1'b0;
    chk("rd_busy_on", rd_busy, 1);
    chk("rd_owner", rd_owner, p);
    if (p) s1_axi_rready = 1'b1; else s0_axi_rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge aclk);
      m_axi_rvalid = 1'b1;
      m_axi_rdata = pat(p, id, b);
      m_axi_rid = id;
      m_axi_rlast = b == int'(len);
      #1;
      chk("r_valid_own", p ? s1_axi_rvalid : s0_axi_rvalid, 1);
      chk("r_valid_other", p ? s0_axi_rvalid : s1_axi_rvalid, 0);
      chk("r_data", p ? s1_axi_rdata : s0_axi_rdata, pat(p, id, b));
      chk("r_last", p ? s1_axi_rlast : s0_axi_rlast, b == int'(len));
      chk("r_ready", m_axi_rready, 1);
      @(posedge aclk);
      #1;
      m_axi_rvalid = 1'b0;
      m_axi_rlast = 1'b0;
    end
    s0_axi_rready = 1'b0;
    s1_axi_rready = 1'b0;
    chk("rd_busy_off", rd_busy, 0);
  endtask

  initial begin
    vec_t vt [5];
    {s0_axi_awid, s0_axi_awaddr, s0_axi_awlen, s0_axi_awlock, s0_axi_awcache, s0_axi_awprot} = '0;
    {s1_axi_awid, s1_axi_awaddr, s1_axi_awlen, s1_axi_awlock, s1_axi_awcache, s1_axi_awprot} = '0;
    {s0_axi_arid, s0_axi_araddr, s0_axi_arlen, s0_axi_arlock, s0_axi_arcache, s0_axi_arprot} = '0;
    {s1_axi_arid, s1_axi_araddr, s1_axi_arlen, s1_axi_arlock, s1_axi_arcache, s1_axi_arprot} = '0;
    s0_axi_awsize = 3'd3; s1_axi_awsize = 3'd3; s0_axi_arsize = 3'd3; s1_axi_arsize = 3'd3;
    s0_axi_awburst = 2'd1; s1_axi_awburst = 2'd2; s0_axi_arburst = 2'd1; s1_axi_arburst = 2'd2;
    s0_axi_arqos = 4'h3; s1_axi_arqos = 4'h9;
    s0_axi_awvalid = 0; s1_axi_awvalid = 0; s0_axi_arvalid = 0; s1_axi_arvalid = 0;
    s0_axi_wdata = '0; s1_axi_wdata = '0; s0_axi_wstrb = 8'hFF; s1_axi_wstrb = 8'hFF;
    s0_axi_wlast = 0; s1_axi_wlast = 0; s0_axi_wvalid = 0; s1_axi_wvalid = 0;
    s0_axi_bready = 0; s1_axi_bready = 0; s0_axi_rready = 0; s1_axi_rready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0; m_axi_rvalid = 0;
    vt[0] = '{p: 1'b0, rd: 1'b0, id: 4'd3, addr: 32'h0000_0100, len: 8'd3, exp_addr: remap(32'h0000_0100)};
    vt[1] = '{p: 1'b1, rd: 1'b0, id: 4'd5, addr: 32'h0000_2000, len: 8'd1, exp_addr: remap(32'h0000_2000)};
    vt[2] = '{p: 1'b1, rd: 1'b1, id: 4'd6, addr: 32'h0000_1000, len: 8'd0, exp_addr: remap(32'h0000_1000)};
    vt[3] = '{p: 1'b0, rd: 1'b1, id: 4'd1, addr: 32'h0000_0044, len: 8'd3, exp_addr: remap(32'h0000_0044)};
    vt[4] = '{p: 1'b0, rd: 1'b0, id: 4'hF, addr: 32'hFFFF_FFF0, len: 8'd0, exp_addr: 32'hFFFF_FFF0};
    // both requesters already waiting while reset is held
    aw_drive(1'b0, 1'b1, 4'd1, 32'h10, 8'd0);
    aw_drive(1'b1, 1'b1, 4'd2, 32'h20, 8'd0);
    m_axi_awready = 1'b1;
    #12;
    chk("rst_m_awvalid", m_axi_awvalid, 0);
    chk("rst_s0_awready", s0_axi_awready, 0);
    chk("rst_busy", {wr_busy, rd_busy, wr_owner, rd_owner}, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    m_axi_awready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      if (r > 0) begin
        @(negedge aclk);
        aw_drive(1'b0, 1'b1, 4'd1, 32'h10, 8'd0);
        aw_drive(1'b1, 1'b1, 4'd2, 32'h20, 8'd0);
      end
      do_write(r[0], r[0] ? 4'd2 : 4'd1, r[0] ? 32'h20 : 32'h10, 8'd0, remap(r[0] ? 32'h20 : 32'h10));
    end
    aw_drive(1'b0, 1'b0, 4'd0, 32'h0, 8'd0);
    aw_drive(1'b1, 1'b0, 4'd0, 32'h0, 8'd0);
    // pointer now prefers port 0: a late s0 request must not steal s1's pending grant
    @(negedge aclk);
    aw_drive(1'b1, 1'b1, 4'd9, 32'h300, 8'd0);
    @(negedge aclk);
    aw_drive(1'b0, 1'b1, 4'd8, 32'h200, 8'd0);
    #1;
    chk("hold_grant_id", m_axi_awid, 4'd9);
    do_write(1'b1, 4'd9, 32'h300, 8'd0, remap(32'h300));
    do_write(1'b0, 4'd8, 32'h200, 8'd0, remap(32'h200));
    for (int i = 0; i < 5; i++)
      if (vt[i].rd) do_read(vt[i].p, vt[i].id, vt[i].addr, vt[i].len, vt[i].exp_addr);
      else do_write(vt[i].p, vt[i].id, vt[i].addr, vt[i].len, vt[i].exp_addr);
    fork
      do_write(1'b0, 4'd3, 32'h700, 8'd1, remap(32'h700));
      do_read(1'b1, 4'd4, 32'h800, 8'd7, remap(32'h800));
    join
    // early W from s1 sits unaccepted through s0's burst
    @(negedge aclk);
    w_drive(1'b1, 1'b1, pat(1'b1, 4'd7, 0), 1'b1);
    #1;
    chk("early_w_idle_mvalid", m_axi_wvalid, 0);
    chk("early_w_idle_ready", s1_axi_wready, 0);
    do_write(1'b0, 4'd2, 32'h500, 8'd1, remap(32'h500));
    chk("early_w_still_pending", s1_axi_wvalid & ~s1_axi_wready, 1);
    do_write(1'b1, 4'd7, 32'h600, 8'd0, remap(32'h600));
    // asynchronous reset during beat 3 of an 8-beat read
    @(negedge aclk);
    ar_drive(1'b0, 1'b1, 4'd5, 32'h80, 8'd7);
    m_axi_arready = 1'b1;
    @(posedge aclk);
    #1;
    ar_drive(1'b0, 1'b0, 4'd5, 32'h80, 8'd7);
    m_axi_arready = 1'b0;
    s0_axi_rready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge aclk);
      m_axi_rvalid = 1'b1;
      @(posedge aclk);
      #1;
      m_axi_rvalid = 1'b0;
    end
    @(negedge aclk);
    m_axi_rvalid = 1'b1;
    s1_axi_awvalid = 1'b1;
    m_axi_awready = 1'b1;
    #1;
    chk("mid_rvalid", s0_axi_rvalid, 1);
    chk("mid_rd_busy", rd_busy, 1);
    aresetn = 1'b0;
    #1;
    chk("arst_rd_busy", rd_busy, 0);
    chk("arst_s0_rvalid", s0_axi_rvalid, 0);
    chk("arst_rready", m_axi_rready, 0);
    chk("arst_awvalid", m_axi_awvalid, 0);
    chk("arst_s1_awready", s1_axi_awready, 0);
    m_axi_rvalid = 1'b0;
    s0_axi_rready = 1'b0;
    s1_axi_awvalid = 1'b0;
    m_axi_awready = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    do_read(1'b0, 4'd6, 32'h0000_1000, 8'd2, remap(32'h0000_1000));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
